// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared packet and scheduler types for the switch fabric
package packet_pkg;

    localparam int NUM_PORTS    = 4;
    localparam int STARVE_LIMIT = 16;
    localparam int ADDR_WIDTH   = NUM_PORTS;

    typedef enum logic [1:0] {P_DATA, P_CTRL, P_MGMT} p_type;

    typedef enum logic [1:0] {IDLE, REQ, XFER} sched_state_t;

endpackage

// File: rtl/switch_scheduler_if.sv
// rtl/switch_scheduler_if.sv - input request / output allocation bundle of the scheduler
interface switch_scheduler_if #(
    parameter int NUM_PORTS = packet_pkg::NUM_PORTS
);

    logic [NUM_PORTS-1:0]                in_valid;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_target;
    logic [NUM_PORTS-1:0]                in_eop;
    logic [NUM_PORTS-1:0]                in_grant;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_src_sel;
    logic [NUM_PORTS-1:0]                out_busy;

    modport master (
        output in_valid, in_target, in_eop,
        input  in_grant, out_src_sel, out_busy
    );

    modport slave (
        input  in_valid, in_target, in_eop,
        output in_grant, out_src_sel, out_busy
    );

endinterface

// File: rtl/sched_in_ctrl.sv
// rtl/sched_in_ctrl.sv - per-input FSM, latched destination mask and starvation counter
module sched_in_ctrl
    import packet_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             eop_i,
    input  logic             win_i,
    output logic             req_o,
    output logic             starving_o,
    output logic             grant_o,
    output logic [WIDTH-1:0] target_o
);

    localparam int CW = $clog2(LIMIT + 1);

    sched_state_t     state_q;
    logic             grant_q;
    logic [WIDTH-1:0] target_q;
    logic [CW-1:0]    wait_q;

    // An empty mask is indistinguishable from no request at all.
    assign req_o      = (state_q != XFER) && valid_i && (|target_i);
    assign starving_o = (state_q == REQ) && (wait_q == CW'(LIMIT));
    assign grant_o    = grant_q;
    assign target_o   = target_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            target_q <= '0;
            wait_q   <= '0;
        end else begin
            case (state_q)
                IDLE, REQ: begin
                    if (req_o && win_i) begin
                        state_q  <= XFER;
                        grant_q  <= 1'b1;
                        target_q <= target_i;
                        wait_q   <= '0;
                    end else if (req_o) begin
                        state_q <= REQ;
                        if (state_q == REQ && wait_q != CW'(LIMIT)) begin
                            wait_q <= wait_q + CW'(1);
                        end
                    end else begin
                        state_q <= IDLE;
                        wait_q  <= '0;
                    end
                end
                XFER: begin
                    if (eop_i) begin
                        state_q  <= IDLE;
                        grant_q  <= 1'b0;
                        target_q <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    grant_q  <= 1'b0;
                    target_q <= '0;
                    wait_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_scheduler.sv
// rtl/switch_scheduler.sv - rotating-priority all-or-nothing multicast crossbar scheduler
module switch_scheduler #(
    parameter int NUM_PORTS    = packet_pkg::NUM_PORTS,
    parameter int STARVE_LIMIT = packet_pkg::STARVE_LIMIT
) (
    input logic               clk,
    input logic               rst_n,
    switch_scheduler_if.slave sif
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]                req;
    logic [NUM_PORTS-1:0]                starving;
    logic [NUM_PORTS-1:0]                grant;
    logic [NUM_PORTS-1:0]                win;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] tgt_q;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] sel;
    logic [NUM_PORTS-1:0]                busy;
    logic [NUM_PORTS-1:0]                starve_mask;
    logic [NUM_PORTS-1:0]                claimed;
    logic [PW-1:0]                       rr_ptr_q;
    logic [PW-1:0]                       rr_ptr_d;
    logic [PW-1:0]                       idx;
    logic                                found;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        sched_in_ctrl #(
            .WIDTH (NUM_PORTS),
            .LIMIT (STARVE_LIMIT)
        ) u_ctrl (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid_i    (sif.in_valid[i]),
            .target_i   (sif.in_target[i]),
            .eop_i      (sif.in_eop[i]),
            .win_i      (win[i]),
            .req_o      (req[i]),
            .starving_o (starving[i]),
            .grant_o    (grant[i]),
            .target_o   (tgt_q[i])
        );
    end

    always_comb begin
        sel  = '0;
        busy = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                sel[j][i] = grant[i] & tgt_q[i][j];
            end
            busy[j] = |sel[j];
        end
    end

    assign sif.in_grant    = grant;
    assign sif.out_src_sel = sel;
    assign sif.out_busy    = busy;

    // Outputs still owned this cycle (even on their eop beat) seed the claim set,
    // and outputs wanted by a starving requester are fenced off from everyone else.
    always_comb begin
        starve_mask = '0;
        claimed     = busy;
        win         = '0;
        found       = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        idx         = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && starving[i]) begin
                starve_mask = starve_mask | sif.in_target[i];
            end
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (req[idx]
                && (starving[idx] || ((sif.in_target[idx] & starve_mask) == '0))
                && ((sif.in_target[idx] & claimed) == '0)) begin
                win[idx] = 1'b1;
                claimed  = claimed | sif.in_target[idx];
                if (!found) begin
                    found    = 1'b1;
                    rr_ptr_d = PW'((int'(idx) + 1) % NUM_PORTS);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_switch_scheduler.sv
// tb/tb_switch_scheduler.sv - self-checking bench for switch_scheduler
module tb_switch_scheduler;
    import packet_pkg::*;

    localparam int N = 4;

    typedef logic [N-1:0][N-1:0] mat_t;

    typedef struct {
        string        name;
        logic [N-1:0] grant;
        mat_t         sel;
        logic [N-1:0] busy;
    } exp_t;

    typedef struct {
        logic [N-1:0] valid;
        mat_t         tgt;
        logic [N-1:0] grant;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[9];
    mat_t t;

    switch_scheduler_if #(.NUM_PORTS(N)) sif ();

    switch_scheduler #(
        .NUM_PORTS    (N),
        .STARVE_LIMIT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    function automatic mat_t mk(logic [3:0] t3, logic [3:0] t2, logic [3:0] t1, logic [3:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic [N-1:0] v, mat_t tg, logic [N-1:0] e);
        sif.in_valid  = v;
        sif.in_target = tg;
        sif.in_eop    = e;
    endtask

    // Expected outputs for the next edge: owner i drives output j when its mask has bit j.
    task automatic push(string name, logic [N-1:0] g, mat_t tg);
        exp_t e;
        e.name  = name;
        e.grant = g;
        e.sel   = '0;
        e.busy  = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) e.sel[j][i] = g[i] & tg[i][j];
            e.busy[j] = |e.sel[j];
        end
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.name, "_grant"}, 32'(sif.in_grant), 32'(e.grant));
            check({e.name, "_sel"}, 32'(sif.out_src_sel), 32'(e.sel));
            check({e.name, "_busy"}, 32'(sif.out_busy), 32'(e.busy));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0, '0, '0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'b0101, mk(4'b0000, 4'b1000, 4'b0000, 4'b0010), 4'b0101};
        vecs[1] = '{4'b0011, mk(4'b0000, 4'b0000, 4'b0100, 4'b0100), 4'b0001};
        vecs[2] = '{4'b1000, mk(4'b1111, 4'b0000, 4'b0000, 4'b0000), 4'b1000};
        vecs[3] = '{4'b1111, mk(4'b1000, 4'b0100, 4'b0010, 4'b0001), 4'b1111};
        vecs[4] = '{4'b0011, mk(4'b0000, 4'b0000, 4'b0001, 4'b0000), 4'b0010};
        vecs[5] = '{4'b1111, mk(4'b1100, 4'b0100, 4'b0001, 4'b0011), 4'b0101};
        vecs[6] = '{4'b0100, mk(4'b0000, 4'b0100, 4'b0000, 4'b0000), 4'b0100};
        vecs[7] = '{4'b0000, mk(4'b1000, 4'b0100, 4'b0010, 4'b0001), 4'b0000};
        vecs[8] = '{4'b0011, mk(4'b0000, 4'b0000, 4'b1111, 4'b0001), 4'b0001};

        // reset holds everything at zero even with all inputs requesting
        rst_n = 1'b0;
        t = mk(4'b1000, 4'b0100, 4'b0010, 4'b0001);
        drive(4'b1111, t, 4'b0000);
        push("rst_hold0", 4'b0000, t);
        tick();
        push("rst_hold1", 4'b0000, t);
        tick();
        rst_n = 1'b1;
        push("rst_first", 4'b1111, t);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_grant", 32'(sif.in_grant), 32'h0);
        check("rst_async_sel", 32'(sif.out_src_sel), 32'h0);
        check("rst_async_busy", 32'(sif.out_busy), 32'h0);
        check("rst_async_rr", 32'(dut.rr_ptr_q), 32'h0);

        for (int n = 0; n < 9; n++) begin
            do_reset();
            drive(vecs[n].valid, vecs[n].tgt, 4'b0000);
            push($sformatf("vec%0d", n), vecs[n].grant, vecs[n].tgt);
            tick();
            drive('0, '0, '0);
        end

        // contention on output 2, handover one cycle after the eop edge
        do_reset();
        t = mk(4'b0000, 4'b0000, 4'b0100, 4'b0100);
        drive(4'b0011, t, 4'b0000);
        push("cont_e1", 4'b0001, t);
        tick();
        check("cont_rr", 32'(dut.rr_ptr_q), 32'd1);
        push("cont_e2", 4'b0001, t);
        tick();
        drive(4'b0010, t, 4'b0001);
        push("cont_eop", 4'b0000, t);
        tick();
        drive(4'b0010, t, 4'b0000);
        push("cont_next", 4'b0010, t);
        tick();

        // multicast waits for every output in its mask
        do_reset();
        t = mk(4'b1111, 4'b0000, 4'b0001, 4'b0000);
        drive(4'b0010, t, 4'b0000);
        push("mc_own", 4'b0010, t);
        tick();
        drive(4'b1010, t, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            push($sformatf("mc_wait%0d", c), 4'b0010, t);
            tick();
        end
        check("mc_in3_req", 32'(dut.g_in[3].u_ctrl.state_q), 32'(REQ));
        drive(4'b1000, t, 4'b0010);
        push("mc_eop", 4'b0000, t);
        tick();
        drive(4'b1000, t, 4'b0000);
        push("mc_grant", 4'b1000, t);
        tick();

        // starvation: in0 blocked by alternating one-beat packets on in1 / in2
        do_reset();
        t = mk(4'b0000, 4'b0010, 4'b0001, 4'b0011);
        drive(4'b0010, t, 4'b0110);
        push("st_e1", 4'b0010, t);
        tick();
        drive(4'b0111, t, 4'b0110);
        for (int e = 2; e <= 21; e++) begin
            logic [N-1:0] g;
            if (e == 19)      g = 4'b0000;
            else if (e >= 20) g = 4'b0001;
            else if (e % 2 == 0) g = 4'b0100;
            else              g = 4'b0010;
            push($sformatf("st_e%0d", e), g, t);
            tick();
            if (e == 18) check("st_wait_sat", 32'(dut.g_in[0].u_ctrl.wait_q), 32'd16);
        end

        // withdrawal from REQ and a zero mask that never wins
        do_reset();
        t = mk(4'b0000, 4'b0000, 4'b0001, 4'b0001);
        drive(4'b0101, t, 4'b0000);
        push("wd_e1", 4'b0001, t);
        tick();
        drive(4'b0111, t, 4'b0000);
        for (int c = 2; c <= 4; c++) begin
            push($sformatf("wd_e%0d", c), 4'b0001, t);
            tick();
        end
        check("wd_req_state", 32'(dut.g_in[1].u_ctrl.state_q), 32'(REQ));
        check("wd_req_wait", 32'(dut.g_in[1].u_ctrl.wait_q), 32'd2);
        drive(4'b0101, t, 4'b0000);
        push("wd_e5", 4'b0001, t);
        tick();
        check("wd_idle_state", 32'(dut.g_in[1].u_ctrl.state_q), 32'(IDLE));
        check("wd_idle_wait", 32'(dut.g_in[1].u_ctrl.wait_q), 32'd0);
        drive(4'b0100, t, 4'b0001);
        push("wd_e6", 4'b0000, t);
        tick();
        drive(4'b0100, t, 4'b0000);
        for (int c = 7; c <= 8; c++) begin
            push($sformatf("wd_e%0d", c), 4'b0000, t);
            tick();
        end
        check("zm_state", 32'(dut.g_in[2].u_ctrl.state_q), 32'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/switch_scheduler.md
SWITCH_SCHEDULER -- requirements
Module: switch_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, the number of input and output ports.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 16, the wait cycles before an input is marked starving.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  NUM_PORTS  input i holds a parser-validated head packet.
REQ-006 in_target  input  NUM_PORTS x ADDR_WIDTH  destination mask of input i, sampled at grant.
REQ-007 in_eop  input  NUM_PORTS  last beat of input i's current packet.
REQ-008 in_grant  output  NUM_PORTS  input i owns its outputs; registered, level, held until its eop beat.
REQ-009 out_src_sel  output  NUM_PORTS x NUM_PORTS  one-hot source input per output; all-zero when idle.
REQ-010 out_busy  output  NUM_PORTS  output j allocated; equals OR of out_src_sel[j].

Function
REQ-011 Each input SHALL run an FSM with states IDLE, REQ and XFER.
REQ-012 IDLE->XFER when in_valid is high and the input wins arbitration; IDLE->REQ when in_valid is high and it loses.
REQ-013 REQ->XFER on a win; REQ->IDLE if in_valid drops (withdrawal).
REQ-014 XFER->IDLE at the edge where in_eop is high; in_valid and in_target SHALL be ignored in XFER.
REQ-015 Arbitration SHALL be combinational each cycle; results SHALL register at the next edge, giving 1-cycle request-to-grant latency.
REQ-016 Requesters SHALL be scanned in rotating priority starting at rr_ptr (2 bits).
REQ-017 A requester SHALL win only if every output in its mask is free and unclaimed by an earlier-scanned winner in the same cycle (all-or-nothing multicast).
REQ-018 Several disjoint requesters SHALL be granted in the same cycle.
REQ-019 When any grant issues, rr_ptr SHALL move to one past the highest-priority winner, mod NUM_PORTS; otherwise it SHALL hold.
REQ-020 Outputs freed by an eop edge SHALL count as busy during that cycle's arbitration; the next owner's grant SHALL rise one cycle after the previous owner's grant falls.
REQ-021 A mask containing the input's own port SHALL be legal (loopback).
REQ-022 in_target == 0 SHALL be treated as in_valid low.
REQ-023 The latched target mask SHALL drive out_src_sel for the whole of XFER.
REQ-024 Each input SHALL have a wait counter that increments in REQ, saturates at STARVE_LIMIT, and clears on grant or on leaving REQ.
REQ-025 A saturated input SHALL be starving; no non-starving input may win an output in any starving input's mask.
REQ-026 Among starving inputs, rotating priority from rr_ptr SHALL apply.
REQ-027 Two outputs SHALL never select the same input unless that input's mask has both bits set.
REQ-028 No output SHALL ever be one-hot-violated or double-owned.

Reset
REQ-029 While rst_n is low, all FSMs SHALL be IDLE and in_grant, out_src_sel, out_busy, rr_ptr, latched targets and wait counters SHALL all be 0.
REQ-030 Assertion SHALL take effect immediately, including mid-packet, with no eop required.
REQ-031 The first arbitration SHALL occur in the first cycle after deassertion.

Structure
REQ-032 packet_pkg SHALL hold NUM_PORTS, STARVE_LIMIT and the enum sched_state_t {IDLE, REQ, XFER}, alongside the existing ADDR_WIDTH and p_type.
REQ-033 One sub-module, sched_in_ctrl, SHALL be instantiated per input and contain the FSM, latched target and wait counter; arbitration and rr_ptr SHALL stay in the top level.

Verification
REQ-034 Reset: rst_n=0 with in_valid=1111 -> in_grant=0000 and out_src_sel all zero; assert rst_n mid-XFER -> all outputs 0 asynchronously.
REQ-035 Disjoint: in0->0010 and in2->1000 valid in cycle 0 -> in_grant=0101 at cycle 1, out_src_sel[1]=0001, out_src_sel[3]=0100.
REQ-036 Contention: in0 and in1 both ->0100 with rr_ptr=0 -> in0 granted and rr_ptr=1; in0 eop at edge k -> in_grant[1] rises at edge k+1.
REQ-037 Multicast all-or-nothing: in1 holds output 0 and in3 requests 1111 -> in3 stays in REQ with outputs 1-3 idle; after in1 eop, in3 granted with out_busy=1111.
REQ-038 Starvation: in0->0011 blocked by alternating 1-beat packets in1->0001 and in2->0010 -> after 16 wait cycles, no new grants to outputs 0 or 1, and in0 is granted once both drain.
REQ-039 Withdrawal and zero mask: in_valid drops in REQ -> IDLE and counter 0; in_target=0000 with in_valid=1 -> never granted.
